uart_tx_ser: RTL and testbench

//  UART transmit serializer: the send side of the UART link whose receive side oversamples and

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_tx_ser.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_ser.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, standard baud divisors
// for a 50 MHz clock and the parity helper used by both link directions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int BAUD_9600   = 5208;
    localparam int BAUD_19200  = 2604;
    localparam int BAUD_38400  = 1302;
    localparam int BAUD_57600  = 868;
    localparam int BAUD_115200 = 434;

    // Parity over a zero-extended data word; zero padding does not change the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the last
// cycle of each bit. Held at zero when disabled or when a new bit is started.
module uart_baud_tick #(
    parameter int BAUD_DIV = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_bit_end,
    output logic o_pre_end
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

    logic [CNT_W-1:0] r_cnt;

    assign o_bit_end = i_en & (r_cnt == CNT_LAST);
    // One cycle ahead of o_bit_end, lets the parent register pulses that land on bit_end.
    assign o_pre_end = i_en & (r_cnt == CNT_PRE);

    // Baud counter: restart at each bit boundary, park at zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || i_clr || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: takes one word over valid/ready and shifts it out
// as start, LSB-first data, optional parity and one or two stop bits.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_nxt;
    logic                 r_stop_idx;
    logic                 w_stop_idx_nxt;
    logic                 r_par;
    logic                 r_tx_out;
    logic                 w_tx_out_nxt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_accept;
    logic                 w_baud_en;
    logic                 w_bit_end;
    logic                 w_pre_end;
    logic                 w_last_stop;

    // Ready is a decode of the registered state, so accept never loops through tx_valid.
    assign w_accept    = tx_valid & (r_state == IDLE);
    assign w_baud_en   = (r_state != IDLE);
    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_baud_en),
        .i_clr     (w_accept),
        .o_bit_end (w_bit_end),
        .o_pre_end (w_pre_end)
    );

    // Next-state, shift, index and line-level logic; everything moves only on bit_end.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_tx_out_nxt   = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = START;
                    w_shift_nxt    = tx_data;
                    w_bit_idx_nxt  = 3'd0;
                    w_stop_idx_nxt = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = r_shift >> 1;
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end else begin
                    w_state_nxt = PARITY;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (w_last_stop) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx_out can be a plain register.
        case (w_state_nxt)
            IDLE:    w_tx_out_nxt = 1'b1;
            START:   w_tx_out_nxt = 1'b0;
            DATA:    w_tx_out_nxt = w_shift_nxt[0];
            PARITY:  w_tx_out_nxt = r_par;
            STOP:    w_tx_out_nxt = 1'b1;
            default: w_tx_out_nxt = 1'b1;
        endcase

        // Done is raised one cycle early so the registered pulse lands on the final bit_end.
        w_done_nxt = (r_state == STOP) & w_last_stop & w_pre_end;
    end

    // State, datapath and output registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_tx_out   <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_tx_out   <= w_tx_out_nxt;
            r_ready    <= (w_state_nxt == IDLE);
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= w_done_nxt;
        end
    end

    // Parity is computed once from the accepted word, never from later tx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= calc_parity(8'(tx_data), (PARITY_ODD != 0));
        end else begin
            r_par <= r_par;
        end
    end

    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign tx_out   = r_tx_out;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: four instances (8N1, 8E1, 8O1 at 16 clk/bit, 8N2 at
// 434 clk/bit) driven from a table of hand-computed frames plus directed
// sequences for back-to-back, busy-ignore and mid-frame reset.
module tb_uart_tx_ser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dat [4];
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] lin;
    logic [3:0] bsy;
    logic [3:0] dne;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_ser #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_out(lin[0]), .tx_busy(bsy[0]), .tx_done(dne[0]));
    uart_tx_ser #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_out(lin[1]), .tx_busy(bsy[1]), .tx_done(dne[1]));
    uart_tx_ser #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_out(lin[2]), .tx_busy(bsy[2]), .tx_done(dne[2]));
    uart_tx_ser #(.BAUD_DIV(434), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[3]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx_out(lin[3]), .tx_busy(bsy[3]), .tx_done(dne[3]));

    // bits: line level of frame bit i at position i (bit 0 = start bit)
    typedef struct {
        int         sel;
        logic [7:0] data;
        int         nb;
        logic [15:0] bits;
        int         baud;
        int         pulse_at;
    } vec_t;

    vec_t vecs [9];

    function automatic int b2i(input logic v);
        return (v === 1'b1) ? 1 : ((v === 1'b0) ? 0 : 2);
    endfunction

    // Line level of 8N1 frame position pos for word d.
    function automatic logic fb(input logic [7:0] d, input int pos);
        if (pos == 0) return 1'b0;
        if (pos >= 1 && pos <= 8) return d[pos-1];
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic drive(input int s, input logic [7:0] d, input logic v);
        dat[s] = d;
        vld[s] = v;
    endtask

    task automatic wait_ready(input int s, input string nm);
        int waited;
        waited = 0;
        while (rdy[s] !== 1'b1 && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        chk({nm, " ready_before_send"}, b2i(rdy[s]), 1);
    endtask

    task automatic check_frame(input string nm, input int s, input logic [7:0] d, input int nb,
                               input logic [15:0] bits, input int baud, input int pulse_at);
        int len, b, done_at, done_cnt, busy_bad, idle_bad;
        int bad [16];
        logic [7:0] rx;
        len = nb * baud;
        done_at = -1; done_cnt = 0; busy_bad = 0; idle_bad = 0; rx = 8'h00;
        for (int i = 0; i < 16; i++) bad[i] = 0;
        @(negedge clk);
        wait_ready(s, nm);
        drive(s, d, 1'b1);
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) drive(s, ~d, 1'b0);
            if (k == pulse_at) drive(s, 8'hFF, 1'b1);
            if (k == pulse_at + 1) drive(s, ~d, 1'b0);
            b = k / baud;
            if (lin[s] !== bits[b]) bad[b]++;
            if (dne[s] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (bsy[s] !== 1'b1 || rdy[s] !== 1'b0) busy_bad++;
            if ((k % baud) == baud / 2 && b >= 1 && b <= 8) rx[b-1] = lin[s];
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (lin[s] !== 1'b1 || rdy[s] !== 1'b1 || bsy[s] !== 1'b0 || dne[s] !== 1'b0) idle_bad++;
        end
        for (int i = 0; i < nb; i++) chk($sformatf("%s bit%0d_wrong_cycles", nm, i), bad[i], 0);
        chk({nm, " done_cycle"}, done_at, len - 1);
        chk({nm, " done_count"}, done_cnt, 1);
        chk({nm, " busy_during_frame_bad"}, busy_bad, 0);
        chk({nm, " idle_after_frame_bad"}, idle_bad, 0);
        chk({nm, " decoded_byte"}, int'(rx), int'(d));
    endtask

    initial begin
        int mism, dcnt, r160, l160, r161, bad_rst;

        vecs[0] = '{0, 8'h55, 10, 16'h02AA, 16, -1};
        vecs[1] = '{0, 8'h01, 10, 16'h0202, 16, -1};
        vecs[2] = '{0, 8'h00, 10, 16'h0200, 16, 50};
        vecs[3] = '{1, 8'h07, 11, 16'h060E, 16, -1};
        vecs[4] = '{2, 8'h07, 11, 16'h040E, 16, -1};
        vecs[5] = '{1, 8'h00, 11, 16'h0400, 16, -1};
        vecs[6] = '{2, 8'h00, 11, 16'h0600, 16, -1};
        vecs[7] = '{1, 8'h80, 11, 16'h0700, 16, -1};
        vecs[8] = '{3, 8'hC3, 11, 16'h0786, 434, -1};

        rst_n = 1'b0;
        vld   = 4'b0000;
        for (int i = 0; i < 4; i++) dat[i] = 8'h00;

        // Reset state of every instance
        #12;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("reset u%0d tx_out", s),   b2i(lin[s]), 1);
            chk($sformatf("reset u%0d tx_ready", s), b2i(rdy[s]), 1);
            chk($sformatf("reset u%0d tx_busy", s),  b2i(bsy[s]), 0);
            chk($sformatf("reset u%0d tx_done", s),  b2i(dne[s]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single frames
        for (int v = 0; v < 9; v++) begin
            check_frame($sformatf("vec%0d", v), vecs[v].sel, vecs[v].data, vecs[v].nb,
                        vecs[v].bits, vecs[v].baud, vecs[v].pulse_at);
        end

        // Back-to-back: valid held through 0xA5, data switched to 0x3C while busy
        mism = 0; dcnt = 0; r160 = -1; l160 = -1; r161 = -1;
        @(negedge clk);
        wait_ready(0, "b2b");
        drive(0, 8'hA5, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 330; k++) begin
            logic e;
            @(negedge clk);
            if (k == 0) dat[0] = 8'h3C;
            if (k == 161) vld[0] = 1'b0;
            if (k < 160)       e = fb(8'hA5, k / 16);
            else if (k == 160) e = 1'b1;
            else if (k < 321)  e = fb(8'h3C, (k - 161) / 16);
            else               e = 1'b1;
            if (lin[0] !== e) mism++;
            if (dne[0] === 1'b1) dcnt++;
            if (k == 160) begin r160 = b2i(rdy[0]); l160 = b2i(lin[0]); end
            if (k == 161) r161 = b2i(rdy[0]);
        end
        chk("b2b line_wrong_cycles", mism, 0);
        chk("b2b done_count", dcnt, 2);
        chk("b2b ready_in_gap", r160, 1);
        chk("b2b line_in_gap", l160, 1);
        chk("b2b ready_after_gap", r161, 0);

        // Reset during data bit 3 of 0x00
        @(negedge clk);
        wait_ready(0, "rst");
        drive(0, 8'h00, 1'b1);
        @(posedge clk);
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            if (k == 0) vld[0] = 1'b0;
        end
        chk("rst line_before", b2i(lin[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("rst tx_out_immediate", b2i(lin[0]), 1);
        chk("rst tx_ready_immediate", b2i(rdy[0]), 1);
        chk("rst tx_busy_immediate", b2i(bsy[0]), 0);
        chk("rst tx_done_immediate", b2i(dne[0]), 0);
        bad_rst = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (dne[0] !== 1'b0 || lin[0] !== 1'b1) bad_rst++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (dne[0] !== 1'b0 || lin[0] !== 1'b1 || rdy[0] !== 1'b1) bad_rst++;
        end
        chk("rst no_resume_no_done", bad_rst, 0);
        check_frame("post_rst", 0, 8'h96, 10, 16'h032C, 16, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
